// File: rtl/chan_delay_line.sv
//------------------------------------------------------------------------------
// Module      : chan_delay_line
// Description : Per-channel delay line for a time-division multichannel
//               datapath. Holds one SIZE-bit word per channel slot across a
//               frame of DEPTH slots, advancing only on the en strobe, and
//               reports the channel slot, frame wrap and fill status of Y.
//               Optional feature macro: DELAY_TAP_EN (adds tap_sel / TAP).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module chan_delay_line #(
  parameter int              SIZE   = 16,
  parameter int              DEPTH  = 32,
  parameter logic [SIZE-1:0] RSTVAL = '0,
  parameter int              CW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            scan_in0,
  input  logic            scan_enable,
  input  logic            test_mode,
  input  logic            en,
  input  logic            init,
  input  logic [SIZE-1:0] X,
`ifdef DELAY_TAP_EN
  input  logic [CW-1:0]   tap_sel,
  output logic [SIZE-1:0] TAP,
`endif
  output logic [SIZE-1:0] Y,
  output logic [CW-1:0]   chan,
  output logic            frame,
  output logic            valid,
  output logic            scan_out0
);

  // Fill counter must be able to hold DEPTH itself (saturation value).
  localparam int            FW        = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_CHAN = CW'(DEPTH - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 1);

  // Stage 0 is the newest word; stage DEPTH-1 doubles as the Y register.
  logic [SIZE-1:0] stage_q [DEPTH];

  logic [CW-1:0] chan_q,  chan_d;
  logic          frame_q, frame_d;
  logic          valid_q, valid_d;
  logic [FW-1:0] fill_q,  fill_d;

  // Scan pins are placeholders for later scan insertion.
  logic w_unused_scan;
  assign w_unused_scan = scan_in0 ^ scan_enable ^ test_mode;

  // Next-state for slot tracking; frame defaults low so it is a single pulse.
  always_comb begin
    chan_d  = chan_q;
    frame_d = 1'b0;
    valid_d = valid_q;
    fill_d  = fill_q;
    if (en) begin
      chan_d  = (chan_q == LAST_CHAN) ? '0 : chan_q + CW'(1);
      frame_d = (chan_q == LAST_CHAN);
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
      valid_d = (fill_q >= FILL_LAST);
    end
  end

  // Slot-tracking registers; init takes priority over a coincident strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_q  <= '0;
      frame_q <= 1'b0;
      valid_q <= 1'b0;
      fill_q  <= '0;
    end else if (init) begin
      chan_q  <= '0;
      frame_q <= 1'b0;
      valid_q <= 1'b0;
      fill_q  <= '0;
    end else begin
      chan_q  <= chan_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      fill_q  <= fill_d;
    end
  end

  // Shift register: one position per strobe, cleared by reset or init.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RSTVAL;
      end
    end else if (init) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RSTVAL;
      end
    end else if (en) begin
      stage_q[0] <= X;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

`ifdef DELAY_TAP_EN
  logic [SIZE-1:0] tap_q, tap_d;

  // Tap mux; out-of-range selects (non-power-of-two DEPTH) read RSTVAL.
  always_comb begin
    tap_d = RSTVAL;
    if (int'(tap_sel) < DEPTH) begin
      tap_d = stage_q[tap_sel];
    end
  end

  // Registered tap, sampled every clock regardless of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_q <= RSTVAL;
    end else if (init) begin
      tap_q <= RSTVAL;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign TAP = tap_q;
`endif

  assign Y         = stage_q[DEPTH-1];
  assign chan      = chan_q;
  assign frame     = frame_q;
  assign valid     = valid_q;
  assign scan_out0 = 1'b0;

endmodule

`default_nettype wire
